noise_gen_mc: RTL and testbench

NOISE_GEN_MC -- requirements
Module: noise_gen_mc

---
 rtl/noise_pkg.sv | 18 +
 rtl/lfsr_core.sv | 75 +++++++
 rtl/noise_gen_mc.sv | 73 +++++++
 tb/tb_noise_gen_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared defaults and reset-seed helper for the multi-channel noise generator.
package noise_pkg;

  localparam int unsigned DefaultW = 8;
  localparam logic [8:0] DefaultPoly = 9'h11D;

  typedef enum logic [1:0] {
    OpHold,
    OpStep,
    OpLoad
  } lfsr_op_e;

  // Channel k comes out of reset holding k+1 so no channel starts locked at zero.
  function automatic logic [31:0] reset_seed(input int unsigned k);
    return 32'(k + 1);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Single Galois right-shift LFSR channel with seed load.
// Zero-lockup recovery is compiled in with NOISE_LOCKUP_RECOVER_EN.
module lfsr_core
  import noise_pkg::*;
#(
  parameter int unsigned W    = DefaultW,
  parameter logic [W:0]  POLY = (W + 1)'(DefaultPoly),
  parameter logic [W-1:0] INIT = W'(1)
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state,
  output logic         lock
);

  lfsr_op_e     op;
  logic [W-1:0] state_d, state_q, shifted;

  assign shifted = state_q[0] ? ((state_q >> 1) ^ POLY[W:1]) : (state_q >> 1);

`ifdef NOISE_LOCKUP_RECOVER_EN
  logic lock_d, lock_q;
  logic fix;
`endif

  always_comb begin
    op = OpHold;
    if (step) begin
      op = OpStep;
    end else if (load) begin
      op = OpLoad;
    end
    state_d = state_q;
    case (op)
      OpStep:  state_d = shifted;
      OpLoad:  state_d = seed;
      default: state_d = state_q;
    endcase
`ifdef NOISE_LOCKUP_RECOVER_EN
    fix = 1'b0;
    if (((op == OpStep) && (state_q == '0)) || ((op == OpLoad) && (seed == '0))) begin
      state_d = W'(1);
      fix     = 1'b1;
    end
    lock_d = lock_q | fix;
`endif
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef NOISE_LOCKUP_RECOVER_EN
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: rtl/noise_gen_mc.sv
// Multi-channel LFSR noise generator: shared step-rate divider, seed handshake, CH channels.
// Optional zero-lockup recovery selected by NOISE_LOCKUP_RECOVER_EN.
module noise_gen_mc
  import noise_pkg::*;
#(
  parameter int unsigned W    = DefaultW,
  parameter logic [W:0]  POLY = (W + 1)'(DefaultPoly),
  parameter int unsigned CH   = 4,
  parameter int unsigned DIVW = 8,
  localparam int unsigned SW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  input  logic            seed_vld,
  input  logic [SW-1:0]   seed_ch,
  input  logic [W-1:0]    seed,
  output logic            seed_rdy,
  output logic [CH*W-1:0] dout,
  output logic            strobe,
  output logic [CH-1:0]   lock
);

  logic [DIVW-1:0] cnt_d, cnt_q;
  logic            strobe_q;
  logic            step_now, load_ok;

  assign step_now = en && (cnt_q == div);
  assign seed_rdy = ~step_now;
  assign load_ok  = seed_vld & seed_rdy;

  // A count above div (div lowered mid-count) restarts at zero without stepping.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (cnt_q >= div) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= step_now;
    end
  end

  assign strobe = strobe_q;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    lfsr_core #(
      .W   (W),
      .POLY(POLY),
      .INIT(W'(reset_seed(k)))
    ) u_core (
      .clk  (clk),
      .arst (arst),
      .step (step_now),
      .load (load_ok && (seed_ch == SW'(k))),
      .seed (seed),
      .state(dout[k*W +: W]),
      .lock (lock[k])
    );
  end

endmodule

// File: tb/tb_noise_gen_mc.sv
// Scoreboard bench for noise_gen_mc; set NOISE_LOCKUP_RECOVER_EN to check recovery.
module tb_noise_gen_mc;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam logic [8:0] POLY = 9'h11D;

  logic        clk = 1'b0;
  logic        arst, en, seed_vld, seed_rdy, strobe;
  logic [7:0]  div, seed;
  logic [1:0]  seed_ch;
  logic [31:0] dout;
  logic [3:0]  lock;

  logic        en3, seed_vld3, seed_rdy3, strobe3;
  logic [7:0]  div3, seed3;
  logic [1:0]  seed_ch3;
  logic [23:0] dout3;
  logic [2:0]  lock3;

  always #5 clk = ~clk;

  noise_gen_mc u_dut (
    .clk(clk), .arst(arst), .en(en), .div(div), .seed_vld(seed_vld), .seed_ch(seed_ch),
    .seed(seed), .seed_rdy(seed_rdy), .dout(dout), .strobe(strobe), .lock(lock)
  );

  noise_gen_mc #(.CH(3)) u_dut3 (
    .clk(clk), .arst(arst), .en(en3), .div(div3), .seed_vld(seed_vld3), .seed_ch(seed_ch3),
    .seed(seed3), .seed_rdy(seed_rdy3), .dout(dout3), .strobe(strobe3), .lock(lock3)
  );

  typedef struct {
    logic [31:0] dout;
    logic        strobe;
    logic [3:0]  lock;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int         m_cnt;
  logic [7:0] m_st[CH];
  logic [3:0] m_lock;
  bit         m_accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] taps;
    taps = 8'(POLY >> 1);
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_lock = '0;
    m_accepted = 1'b0;
    for (int k = 0; k < CH; k++) m_st[k] = 8'(k + 1);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic tick();
    bit   step;
    exp_t e;
    step = en && (m_cnt == int'(div));
    m_accepted = seed_vld && !step;
    if (step) begin
      for (int k = 0; k < CH; k++) begin
        m_st[k] = lfsr_next(m_st[k]);
`ifdef NOISE_LOCKUP_RECOVER_EN
        if (m_st[k] == 8'h00) begin
          m_st[k] = 8'h01;
          m_lock[k] = 1'b1;
        end
`endif
      end
    end
    if (m_accepted && int'(seed_ch) < CH) begin
      m_st[seed_ch] = seed;
`ifdef NOISE_LOCKUP_RECOVER_EN
      if (seed == 8'h00) begin
        m_st[seed_ch] = 8'h01;
        m_lock[seed_ch] = 1'b1;
      end
`endif
    end
    if (en) m_cnt = (m_cnt >= int'(div)) ? 0 : m_cnt + 1;
    e.dout   = {m_st[3], m_st[2], m_st[1], m_st[0]};
    e.strobe = step;
    e.lock   = m_lock;
    e.rdy    = !(en && (m_cnt == int'(div)));
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dout", dout, e.dout);
        check("strobe", {31'd0, strobe}, {31'd0, e.strobe});
        check("lock", {28'd0, lock}, {28'd0, e.lock});
        check("seed_rdy", {31'd0, seed_rdy}, {31'd0, e.rdy});
      end
    end
  end

  initial begin : stim
    arst = 1'b0; en = 1'b0; div = '0; seed_vld = 1'b0; seed_ch = '0; seed = '0;
    en3 = 1'b0; div3 = '0; seed_vld3 = 1'b0; seed_ch3 = '0; seed3 = '0;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_dout", dout, 32'h04030201);
    check("reset_strobe", {31'd0, strobe}, 32'd0);
    check("reset_lock", {28'd0, lock}, 32'd0);
    check("reset_rdy", {31'd0, seed_rdy}, 32'd1);
    check("reset_dout3", {8'd0, dout3}, 32'h00030201);
    @(negedge clk);
    arst = 1'b1;

    // Full-rate stepping: known prefix and period 255 on channel 0.
    en = 1'b1; div = 8'd0;
    tick(); check("seq_8e", {24'd0, dout[7:0]}, 32'h8E);
    tick(); check("seq_47", {24'd0, dout[7:0]}, 32'h47);
    tick(); check("seq_ad", {24'd0, dout[7:0]}, 32'hAD);
    for (int i = 3; i < 255; i++) begin
      tick();
      if (i < 254) check("no_early_wrap", {31'd0, dout[7:0] == 8'h01}, 32'd0);
    end
    check("period_255", {24'd0, dout[7:0]}, 32'h01);

    // div=3 with an enable gap, then div lowered below the count.
    div = 8'd3;
    for (int i = 0; i < 6; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    div = 8'd7;
    for (int i = 0; i < 12 && m_cnt != 5; i++) tick();
    check("cnt_reached_5", m_cnt, 5);
    div = 8'd2;
    tick();
    check("lowered_div_no_step", {31'd0, strobe}, 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // Seed request landing on a step cycle is stalled one cycle.
    div = 8'd3;
    for (int i = 0; i < 8 && m_cnt != 3; i++) tick();
    seed_vld = 1'b1; seed_ch = 2'd2; seed = 8'h55;
    #1 check("stall_rdy", {31'd0, seed_rdy}, 32'd0);
    tick();
    check("stall_rdy_after", {31'd0, seed_rdy}, 32'd1);
    tick();
    seed_vld = 1'b0;
    check("seed_ch2", {24'd0, dout[23:16]}, 32'h55);

    // Zero seed into channel 1, then step it ten times.
    en = 1'b0;
    seed_vld = 1'b1; seed_ch = 2'd1; seed = 8'h00;
    tick();
    seed_vld = 1'b0;
    en = 1'b1; div = 8'd0;
    for (int i = 0; i < 10; i++) tick();
`ifdef NOISE_LOCKUP_RECOVER_EN
    check("zero_lock", {28'd0, lock}, 32'h2);
`else
    check("zero_stuck", {24'd0, dout[15:8]}, 32'h00);
    check("zero_lock", {28'd0, lock}, 32'h0);
`endif

    // Out-of-range channel on a three-channel instance.
    en = 1'b0;
    seed_vld3 = 1'b1; seed_ch3 = 2'd3; seed3 = 8'h55;
    #1 check("oor_rdy", {31'd0, seed_rdy3}, 32'd1);
    tick();
    check("oor_no_change", {8'd0, dout3}, 32'h00030201);
    seed_ch3 = 2'd2;
    tick();
    seed_vld3 = 1'b0;
    check("ch3_load", {8'd0, dout3}, 32'h00550201);

    // Randomized traffic with a source that holds requests until accepted.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) div = 8'($urandom % 6);
      if (!seed_vld || m_accepted) begin
        seed_vld = ($urandom % 4) == 0;
        seed_ch  = 2'($urandom % 4);
        seed     = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      end
      tick();
    end
    seed_vld = 1'b0;

    // Asynchronous reset mid-count, then a full div=5 period before the first strobe.
    en = 1'b1; div = 8'd5;
    tick(); tick(); tick();
    #2 arst = 1'b0;
    #1;
    check("async_dout", dout, 32'h04030201);
    check("async_strobe", {31'd0, strobe}, 32'd0);
    check("async_lock", {28'd0, lock}, 32'd0);
    model_reset();
    @(negedge clk);
    arst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_quiet", {31'd0, strobe}, 32'd0);
    end
    tick();
    check("post_reset_strobe", {31'd0, strobe}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
